// File: rtl/arb_mux_pkg.sv
// Shared mode encodings and grant-index helper for the arb_mux N:1 streaming multiplexer.
// Mode 2'b11 has no constant of its own; the datapath treats it as fixed priority.
package arb_mux_pkg;

   localparam logic [1:0] MODE_SELECT = 2'b00;
   localparam logic [1:0] MODE_PRIO   = 2'b01;
   localparam logic [1:0] MODE_RR     = 2'b10;

   localparam int MAX_CHANNELS = 16;

   // Grant is one-hot, so OR-ing the indices of the set bits yields the single index.
   function automatic int onehot_to_idx(input logic [MAX_CHANNELS-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between producers, the arb_mux and its consumer.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface arb_mux_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [1:0]              mode;
   logic [SEL_W-1:0]        sel;
   logic [CHANNELS-1:0]     in_valid;
   logic [CHANNELS-1:0]     in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_chan;

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or after ptr, wrapping.
// Purely combinational; a zero pointer degenerates to lowest-index-first priority.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N:1 valid/ready multiplexer (select / fixed priority / round-robin) into one output register.
// Latency 1 cycle; a stalled output drops every in_ready, a draining output reloads with no bubble.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   arb_mux_if.slave  bus
);

   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS-1:0]     sel_grant;
   logic [CHANNELS-1:0]     prio_grant;
   logic [CHANNELS-1:0]     rr_grant;
   logic [CHANNELS-1:0]     grant;
   logic [MAX_CHANNELS-1:0] grant_ext;
   logic [SEL_W-1:0]        rr_ptr;
   logic [SEL_W-1:0]        gnt_idx;
   logic [WIDTH-1:0]        gnt_data;
   logic                    load_en;
   logic                    xfer;

   rr_arbiter #(.N(CHANNELS)) u_rr (
      .req   (bus.in_valid),
      .ptr   (rr_ptr),
      .grant (rr_grant)
   );

   rr_arbiter #(.N(CHANNELS)) u_prio (
      .req   (bus.in_valid),
      .ptr   ('0),
      .grant (prio_grant)
   );

   // sel can exceed the channel count when CHANNELS is not a power of two.
   always_comb begin
      sel_grant = '0;
      if ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS))
         sel_grant[bus.sel] = bus.in_valid[bus.sel];
   end

   always_comb begin
      case (bus.mode)
         MODE_SELECT: grant = sel_grant;
         MODE_RR:     grant = rr_grant;
         default:     grant = prio_grant;
      endcase
   end

   always_comb begin
      grant_ext                = '0;
      grant_ext[CHANNELS-1:0]  = grant;
   end

   assign load_en  = !bus.out_valid || bus.out_ready;
   assign xfer     = (|grant) && load_en;
   assign gnt_idx  = SEL_W'(onehot_to_idx(grant_ext));
   assign gnt_data = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];

   // Gated by rst_n so producers never see a handshake while the register is held clear.
   assign bus.in_ready = rst_n ? (grant & {CHANNELS{load_en}}) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         rr_ptr        <= '0;
      end else begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= gnt_data;
            bus.out_chan  <= gnt_idx;
            if (bus.mode == MODE_RR)
               rr_ptr <= (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + 1'b1;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios plus random traffic against a queue-free behavioural model.
// A second 3-channel instance covers the out-of-range select and mode 2'b11.
module tb_arb_mux;
   import arb_mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   arb_mux_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
   arb_mux_if #(.WIDTH(32), .CHANNELS(3)) bus3 ();

   arb_mux #(.WIDTH(32), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   arb_mux #(.WIDTH(32), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   int n_checks = 0;
   int n_errors = 0;

   bit          m_valid;
   logic [31:0] m_data;
   int          m_chan;
   int          m_ptr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns the granted channel or -1, straight from the arbitration rules.
   function automatic int model_grant(input logic [1:0] md, input int s, input logic [3:0] v,
                                      input int p, input int n);
      if (md == 2'b00) return (s < n && v[s]) ? s : -1;
      if (md == 2'b10) begin
         for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
         return -1;
      end
      for (int c = 0; c < n; c++)
         if (v[c]) return c;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
   endtask

   // One clock of the 4-channel DUT, checked against the model before and after the edge.
   task automatic step4();
      int         g;
      bit         load;
      logic [3:0] exp_rdy;
      logic [31:0] d;
      #1;
      load    = !m_valid || bus4.out_ready;
      g       = model_grant(bus4.mode, int'(bus4.sel), bus4.in_valid, m_ptr, 4);
      exp_rdy = (g >= 0 && load) ? 4'(1 << g) : 4'b0000;
      d       = (g >= 0) ? bus4.in_data[g*32 +: 32] : 32'h0;
      chk("in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (g >= 0 && load) begin
         m_valid = 1'b1;
         m_data  = d;
         m_chan  = g;
         if (bus4.mode == 2'b10) m_ptr = (g + 1) % 4;
      end else if (bus4.out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", 64'(bus4.out_valid), 64'(m_valid));
      chk("out_data",  64'(bus4.out_data),  64'(m_data));
      chk("out_chan",  64'(bus4.out_chan),  64'(m_chan));
   endtask

   initial begin
      logic [31:0] held_data;
      logic [1:0]  held_chan;
      logic [31:0] v;

      rst_n          = 1'b0;
      bus4.mode      = MODE_SELECT;
      bus4.sel       = 2'd0;
      bus4.in_valid  = 4'b1111;
      bus4.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus4.out_ready = 1'b1;
      bus3.mode      = MODE_SELECT;
      bus3.sel       = 2'd0;
      bus3.in_valid  = 3'b000;
      bus3.in_data   = '0;
      bus3.out_ready = 1'b1;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus4.out_data),  64'd0);
      chk("rst_out_chan",  64'(bus4.out_chan),  64'd0);
      chk("rst_in_ready",  64'(bus4.in_ready),  64'd0);
      rst_n = 1'b1;

      bus4.sel = 2'd2;
      bus4.in_data[2*32 +: 32] = 32'hDEADBEEF;
      #1;
      chk("sel_in_ready", 64'(bus4.in_ready), 64'b0100);
      step4();
      chk("sel_out_data", 64'(bus4.out_data), 64'hDEADBEEF);
      chk("sel_out_chan", 64'(bus4.out_chan), 64'd2);

      // Asynchronous reset while the output register is full.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus4.out_valid), 64'd0);
      chk("arst_out_data",  64'(bus4.out_data),  64'd0);
      chk("arst_out_chan",  64'(bus4.out_chan),  64'd0);
      chk("arst_in_ready",  64'(bus4.in_ready),  64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      bus4.mode     = MODE_PRIO;
      bus4.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         bus4.in_data = {$urandom, $urandom, $urandom, $urandom};
         step4();
         chk("prio_chan", 64'(bus4.out_chan), 64'd1);
         chk("prio_rdy3", 64'(bus4.in_ready[3]), 64'd0);
      end

      bus4.mode     = MODE_RR;
      bus4.in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         bus4.in_data = {$urandom, $urandom, $urandom, $urandom};
         step4();
         chk("rr_chan",  64'(bus4.out_chan),  64'(i % 4));
         chk("rr_valid", 64'(bus4.out_valid), 64'd1);
      end

      held_data      = bus4.out_data;
      held_chan      = bus4.out_chan;
      bus4.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus4.in_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("bp_in_ready", 64'(bus4.in_ready), 64'd0);
         step4();
         chk("bp_data", 64'(bus4.out_data), 64'(held_data));
         chk("bp_chan", 64'(bus4.out_chan), 64'(held_chan));
      end
      v              = $urandom;
      bus4.out_ready = 1'b1;
      bus4.mode      = MODE_PRIO;
      bus4.in_valid  = 4'b0001;
      bus4.in_data[31:0] = v;
      #1;
      chk("bp_reload_rdy", 64'(bus4.in_ready), 64'b0001);
      step4();
      chk("bp_reload_valid", 64'(bus4.out_valid), 64'd1);
      chk("bp_reload_chan",  64'(bus4.out_chan),  64'd0);
      chk("bp_reload_data",  64'(bus4.out_data),  64'(v));

      // Three-channel instance: out-of-range select, then mode 2'b11.
      bus4.in_valid = 4'b0000;
      bus3.mode     = 2'b00;
      bus3.sel      = 2'd3;
      bus3.in_valid = 3'b111;
      bus3.in_data  = {$urandom, $urandom, $urandom};
      #1;
      chk("b3_sel_rdy", 64'(bus3.in_ready), 64'd0);
      step4();
      chk("b3_sel_valid", 64'(bus3.out_valid), 64'd0);
      v             = $urandom;
      bus3.mode     = 2'b11;
      bus3.in_valid = 3'b110;
      bus3.in_data[32 +: 32] = v;
      #1;
      chk("b3_m11_rdy", 64'(bus3.in_ready), 64'b010);
      step4();
      chk("b3_m11_valid", 64'(bus3.out_valid), 64'd1);
      chk("b3_m11_chan",  64'(bus3.out_chan),  64'd1);
      chk("b3_m11_data",  64'(bus3.out_data),  64'(v));

      for (int i = 0; i < 400; i++) begin
         bus4.mode      = 2'($urandom_range(3, 0));
         bus4.sel       = 2'($urandom_range(3, 0));
         bus4.in_valid  = 4'($urandom_range(15, 0));
         bus4.in_data   = {$urandom, $urandom, $urandom, $urandom};
         bus4.out_ready = ($urandom_range(3, 0) != 0);
         step4();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
